lifo_stack: RTL and testbench

- Decoupled-handshake LIFO buffer: the push/pop counterpart to the FIFO queue utility.
- Entries enter on `push` and leave on `pop` in reverse order; the most recent entry is always presented on `pop`.
- Primary use: return-address stack for the front end. It can also serve any block that needs last-in-first-out buffering of `Data` on `decoupled` interfaces.
- Optional overwrite-on-full mode drops the oldest entry, giving a circular RAS.

---
 rtl/lifo_stack.sv | 70 +++++++
 tb/tb_lifo_stack.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_stack.sv
// Decoupled-handshake LIFO with optional overwrite-on-full (circular return-address stack).
// DEPTH must be >= 2 and need not be a power of two; top index wraps modulo DEPTH.
module lifo_stack #(
    parameter type         data_t    = logic [31:0],
    parameter int unsigned DEPTH     = 4,
    parameter bit          OVERWRITE = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_valid,
    output logic                         push_ready,
    input  data_t                        push_data,
    output logic                         pop_valid,
    input  logic                         pop_ready,
    output data_t                        pop_data,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned TW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [TW-1:0] top;
    logic [TW-1:0] top_m1;
    logic [TW-1:0] top_p1;
    logic [TW-1:0] wr_idx;
    logic          push_fire;
    logic          pop_fire;
    data_t         store [DEPTH];

    // Modulo-DEPTH neighbours of the free-slot index
    assign top_m1 = (top == '0) ? TW'(DEPTH - 1) : top - TW'(1);
    assign top_p1 = (top == TW'(DEPTH - 1)) ? '0 : top + TW'(1);

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign pop_valid  = !empty && !flush;
    assign pop_data   = store[top_m1];
    assign pop_fire   = pop_valid && pop_ready;
    assign push_ready = !flush && (!full || OVERWRITE || pop_fire);
    assign push_fire  = push_valid && push_ready;

    // Simultaneous push/pop replaces the current top in place
    assign wr_idx = pop_fire ? top_m1 : top;

    always_ff @(posedge clk) begin
        if (!rst) begin
            top   <= '0;
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (push_fire && !pop_fire) begin
            top   <= top_p1;
            count <= full ? count : count + CW'(1);
        end else if (pop_fire && !push_fire) begin
            top   <= top_m1;
            count <= count - CW'(1);
        end
    end

    // Storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (rst && push_fire) begin
            store[wr_idx] <= push_data;
        end
    end

endmodule

// File: tb/tb_lifo_stack.sv
// Directed bench for lifo_stack: three instances (D4 stall, D4 overwrite, D3 overwrite).
module tb_lifo_stack;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       push_valid [3];
    logic       push_ready [3];
    logic [7:0] push_data  [3];
    logic       pop_valid  [3];
    logic       pop_ready  [3];
    logic [7:0] pop_data   [3];
    logic       flush      [3];
    logic [2:0] count      [3];
    logic [1:0] count_d3;
    logic       full       [3];
    logic       empty      [3];

    int compared = 0;
    int mismatched = 0;
    bit inv_en = 1'b0;

    always #5 clk = ~clk;

    lifo_stack #(.data_t(logic [7:0]), .DEPTH(4), .OVERWRITE(1'b0)) u_d4 (
        .clk(clk), .rst(rst),
        .push_valid(push_valid[0]), .push_ready(push_ready[0]), .push_data(push_data[0]),
        .pop_valid(pop_valid[0]), .pop_ready(pop_ready[0]), .pop_data(pop_data[0]),
        .flush(flush[0]), .count(count[0]), .full(full[0]), .empty(empty[0]));

    lifo_stack #(.data_t(logic [7:0]), .DEPTH(4), .OVERWRITE(1'b1)) u_d4o (
        .clk(clk), .rst(rst),
        .push_valid(push_valid[1]), .push_ready(push_ready[1]), .push_data(push_data[1]),
        .pop_valid(pop_valid[1]), .pop_ready(pop_ready[1]), .pop_data(pop_data[1]),
        .flush(flush[1]), .count(count[1]), .full(full[1]), .empty(empty[1]));

    lifo_stack #(.data_t(logic [7:0]), .DEPTH(3), .OVERWRITE(1'b1)) u_d3o (
        .clk(clk), .rst(rst),
        .push_valid(push_valid[2]), .push_ready(push_ready[2]), .push_data(push_data[2]),
        .pop_valid(pop_valid[2]), .pop_ready(pop_ready[2]), .pop_data(pop_data[2]),
        .flush(flush[2]), .count(count_d3), .full(full[2]), .empty(empty[2]));

    assign count[2] = {1'b0, count_d3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one instance and let the combinational outputs settle
    task automatic drive(input int i, input logic pv, input logic [7:0] pd,
                         input logic pr, input logic fl);
        push_valid[i] = pv;
        push_data[i]  = pd;
        pop_ready[i]  = pr;
        flush[i]      = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input int i, input logic [7:0] d);
        drive(i, 1'b1, d, 1'b0, 1'b0);
        tick();
        drive(i, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic pop_chk(input int i, input string tag, input logic [7:0] exp);
        drive(i, 1'b0, 8'h00, 1'b1, 1'b0);
        chk({tag, "_valid"}, 32'(pop_valid[i]), 32'd1);
        chk(tag, 32'(pop_data[i]), 32'(exp));
        tick();
        drive(i, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Occupancy flags must track count on every cycle
    always @(negedge clk) begin
        if (inv_en) begin
            for (int i = 0; i < 3; i++) begin
                int dep;
                dep = (i == 2) ? 3 : 4;
                chk("inv_count_le_depth", 32'(count[i] <= 3'(dep)), 32'd1);
                chk("inv_full", 32'(full[i]), 32'(count[i] == 3'(dep)));
                chk("inv_empty", 32'(empty[i]), 32'(count[i] == 3'd0));
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            push_valid[i] = 1'b0;
            push_data[i]  = 8'h00;
            pop_ready[i]  = 1'b0;
            flush[i]      = 1'b0;
        end
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        inv_en = 1'b1;

        // Reset state
        for (int i = 0; i < 3; i++) begin
            chk("rst_count", 32'(count[i]), 32'd0);
            chk("rst_empty", 32'(empty[i]), 32'd1);
            chk("rst_full", 32'(full[i]), 32'd0);
            chk("rst_pop_valid", 32'(pop_valid[i]), 32'd0);
            chk("rst_push_ready", 32'(push_ready[i]), 32'd1);
        end

        // Push A,B,C then pop in reverse order
        push1(0, 8'hA1);
        push1(0, 8'hB2);
        push1(0, 8'hC3);
        chk("abc_count", 32'(count[0]), 32'd3);
        pop_chk(0, "abc_pop_c", 8'hC3);
        pop_chk(0, "abc_pop_b", 8'hB2);
        pop_chk(0, "abc_pop_a", 8'hA1);
        chk("abc_empty", 32'(empty[0]), 32'd1);
        chk("abc_pop_valid", 32'(pop_valid[0]), 32'd0);

        // Full stall then simultaneous push/pop
        push1(0, 8'h11);
        push1(0, 8'h12);
        push1(0, 8'h13);
        push1(0, 8'h14);
        chk("full_count", 32'(count[0]), 32'd4);
        chk("full_flag", 32'(full[0]), 32'd1);
        drive(0, 1'b1, 8'h15, 1'b0, 1'b0);
        chk("stall_push_ready", 32'(push_ready[0]), 32'd0);
        tick();
        chk("stall_count", 32'(count[0]), 32'd4);
        chk("stall_top", 32'(pop_data[0]), 32'h14);
        drive(0, 1'b1, 8'h15, 1'b1, 1'b0);
        chk("swap_push_ready", 32'(push_ready[0]), 32'd1);
        chk("swap_old_top", 32'(pop_data[0]), 32'h14);
        tick();
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("swap_new_top", 32'(pop_data[0]), 32'h15);
        chk("swap_count", 32'(count[0]), 32'd4);
        pop_chk(0, "swap_pop0", 8'h15);
        pop_chk(0, "swap_pop1", 8'h13);
        pop_chk(0, "swap_pop2", 8'h12);
        pop_chk(0, "swap_pop3", 8'h11);
        chk("swap_empty", 32'(empty[0]), 32'd1);

        // Simultaneous push/pop at count=2
        push1(0, 8'h21);
        push1(0, 8'h22);
        drive(0, 1'b1, 8'h33, 1'b1, 1'b0);
        chk("mid_old_top", 32'(pop_data[0]), 32'h22);
        chk("mid_push_ready", 32'(push_ready[0]), 32'd1);
        tick();
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("mid_new_top", 32'(pop_data[0]), 32'h33);
        chk("mid_count", 32'(count[0]), 32'd2);
        pop_chk(0, "mid_pop0", 8'h33);
        pop_chk(0, "mid_pop1", 8'h21);

        // No same-cycle bypass into an empty stack
        drive(0, 1'b1, 8'h44, 1'b1, 1'b0);
        chk("bypass_pop_valid", 32'(pop_valid[0]), 32'd0);
        tick();
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("bypass_count", 32'(count[0]), 32'd1);
        pop_chk(0, "bypass_pop", 8'h44);

        // Overwrite mode, DEPTH=4: push 1..6
        for (int k = 1; k <= 6; k++) begin
            push1(1, 8'(k));
        end
        chk("ovw_count", 32'(count[1]), 32'd4);
        chk("ovw_full", 32'(full[1]), 32'd1);
        drive(1, 1'b1, 8'h77, 1'b0, 1'b0);
        chk("ovw_push_ready_full", 32'(push_ready[1]), 32'd1);
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
        pop_chk(1, "ovw_pop6", 8'h06);
        pop_chk(1, "ovw_pop5", 8'h05);
        pop_chk(1, "ovw_pop4", 8'h04);
        pop_chk(1, "ovw_pop3", 8'h03);
        chk("ovw_empty", 32'(empty[1]), 32'd1);

        // DEPTH=3 overwrite wrap
        for (int k = 1; k <= 5; k++) begin
            push1(2, 8'(k));
        end
        chk("d3_count", 32'(count[2]), 32'd3);
        pop_chk(2, "d3_pop5", 8'h05);
        pop_chk(2, "d3_pop4", 8'h04);
        pop_chk(2, "d3_pop3", 8'h03);
        chk("d3_empty", 32'(empty[2]), 32'd1);

        // Flush mid-stream blocks both sides and clears occupancy
        push1(2, 8'h07);
        push1(2, 8'h08);
        drive(2, 1'b1, 8'h09, 1'b1, 1'b1);
        chk("flush_push_ready", 32'(push_ready[2]), 32'd0);
        chk("flush_pop_valid", 32'(pop_valid[2]), 32'd0);
        tick();
        drive(2, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("flush_count", 32'(count[2]), 32'd0);
        chk("flush_empty", 32'(empty[2]), 32'd1);

        // Mid-operation reset with count=3
        push1(0, 8'h51);
        push1(0, 8'h52);
        push1(0, 8'h53);
        chk("prerst_count", 32'(count[0]), 32'd3);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rst2_count", 32'(count[0]), 32'd0);
        chk("rst2_pop_valid", 32'(pop_valid[0]), 32'd0);
        chk("rst2_push_ready", 32'(push_ready[0]), 32'd1);
        tick();
        chk("rst2_count_hold", 32'(count[0]), 32'd0);

        inv_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
